// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer.
// Back-to-back words go out with no gap. sframe marks valid bits and slast marks the final bit of each word.
module shift_reg_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             slast
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             xfer;
    logic             do_load;
    logic             do_adv;
    logic             buf_wr;
    logic             buf_pop;
    logic [WIDTH-1:0] load_word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign load_ready = !buf_full;
    assign xfer       = load_valid && load_ready;
    assign cnt_nxt    = cnt + CNT_W'(1);

    // The buffered word wins over a bypass at the word boundary.
    // While the buffer is full, load_ready is low, so both can never apply at once.
    always_comb begin
        do_load   = 1'b0;
        do_adv    = 1'b0;
        buf_wr    = 1'b0;
        buf_pop   = 1'b0;
        load_word = d;
        case (state)
            IDLE: do_load = xfer;
            SHIFT: begin
                if (cnt == LAST) begin
                    if (buf_full) begin
                        do_load   = 1'b1;
                        buf_pop   = 1'b1;
                        load_word = buf_data;
                    end else begin
                        do_load = xfer;
                    end
                end else begin
                    do_adv = 1'b1;
                    buf_wr = xfer;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            buf_full <= 1'b0;
            cnt      <= '0;
            sdata    <= 1'b0;
            sframe   <= 1'b0;
            slast    <= 1'b0;
        end else begin
            if (do_load) begin
                state  <= SHIFT;
                cnt    <= '0;
                sdata  <= first_bit(load_word);
                sframe <= 1'b1;
                slast  <= 1'b0;
            end else if (do_adv) begin
                cnt   <= cnt_nxt;
                sdata <= first_bit(shift_out(shreg));
                slast <= (cnt_nxt == LAST);
            end else if (state == SHIFT) begin
                state  <= IDLE;
                cnt    <= '0;
                sdata  <= 1'b0;
                sframe <= 1'b0;
                slast  <= 1'b0;
            end
            if (buf_wr)
                buf_full <= 1'b1;
            else if (buf_pop)
                buf_full <= 1'b0;
        end
    end

    // Data registers carry no reset; their contents only matter once a load qualifies them.
    always_ff @(posedge clk) begin
        if (do_load)
            shreg <= load_word;
        else if (do_adv)
            shreg <= shift_out(shreg);
        if (buf_wr)
            buf_data <= d;
    end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx: handshake, framing, back-to-back, bypass, reset, LSB-first.
// A random traffic phase is checked against a deserializer model.
module tb_shift_reg_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d;
    logic       load_valid;
    logic       load_ready, sdata, sframe, slast;
    logic [7:0] d_l;
    logic       load_valid_l;
    logic       load_ready_l, sdata_l, sframe_l, slast_l;

    int vectors = 0;
    int errors  = 0;

    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .d(d), .load_valid(load_valid),
        .load_ready(load_ready), .sdata(sdata), .sframe(sframe), .slast(slast)
    );

    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .d(d_l), .load_valid(load_valid_l),
        .load_ready(load_ready_l), .sdata(sdata_l), .sframe(sframe_l), .slast(slast_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input int k, input logic [15:0] stream,
                           input logic exp_last);
        chk($sformatf("%s sdata[%0d]", tag, k), {31'd0, sdata}, {31'd0, stream[15-k]});
        chk($sformatf("%s sframe[%0d]", tag, k), {31'd0, sframe}, 32'd1);
        chk($sformatf("%s slast[%0d]", tag, k), {31'd0, slast}, {31'd0, exp_last});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " sframe"}, {31'd0, sframe}, 32'd0);
        chk({tag, " slast"}, {31'd0, slast}, 32'd0);
        chk({tag, " sdata"}, {31'd0, sdata}, 32'd0);
        chk({tag, " load_ready"}, {31'd0, load_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] stream;
        logic [7:0]  q[$];
        logic [7:0]  rx_word;
        int          rx_bits, rx_words, frame_cycles, sent;
        logic        xfer;

        reset = 1'b1; d = 8'h00; load_valid = 1'b0; d_l = 8'h00; load_valid_l = 1'b0;

        // reset
        tick(); tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("post_reset");
        chk("lsb load_ready", {31'd0, load_ready_l}, 32'd1);

        // single word A5
        d = 8'hA5; load_valid = 1'b1;
        tick();
        load_valid = 1'b0; d = 8'h5A;
        stream = 16'hA500;
        for (int k = 0; k < 8; k++) begin
            chk_bit("single", k, stream, k == 7);
            tick();
        end
        chk_idle("single_end");

        // back-to-back A5, 3C
        d = 8'hA5; load_valid = 1'b1;
        tick();
        stream = 16'hA53C;
        chk_bit("b2b", 0, stream, 1'b0);
        chk("b2b ready0", {31'd0, load_ready}, 32'd1);
        d = 8'h3C;
        tick();
        load_valid = 1'b0; d = 8'hFF;
        for (int k = 1; k < 16; k++) begin
            chk_bit("b2b", k, stream, (k == 7) || (k == 15));
            if (k == 1 || k == 7 || k == 8)
                chk($sformatf("b2b ready[%0d]", k), {31'd0, load_ready}, {31'd0, k >= 8});
            tick();
        end
        chk_idle("b2b_end");

        // bypass: FF then 00 offered only on the last-bit edge
        d = 8'hFF; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        stream = 16'hFF00;
        for (int k = 0; k < 16; k++) begin
            chk_bit("bypass", k, stream, (k == 7) || (k == 15));
            if (k == 7) begin
                d = 8'h00; load_valid = 1'b1;
            end
            tick();
            load_valid = 1'b0; d = 8'hAA;
        end
        chk_idle("bypass_end");

        // mid-frame reset with 3C buffered; handshake on the reset edge is ignored
        d = 8'hA5; load_valid = 1'b1;
        tick();
        d = 8'h3C;
        tick();
        load_valid = 1'b0;
        chk("mid buffered ready", {31'd0, load_ready}, 32'd0);
        tick();
        reset = 1'b1; load_valid = 1'b1; d = 8'h3C;
        tick();
        reset = 1'b0; load_valid = 1'b0;
        chk_idle("mid_reset");
        tick();
        chk_idle("mid_reset_hold");
        d = 8'h81; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        stream = 16'h8100;
        for (int k = 0; k < 8; k++) begin
            chk_bit("after_reset", k, stream, k == 7);
            tick();
        end
        chk_idle("after_reset_end");

        // LSB-first instance
        d_l = 8'h01; load_valid_l = 1'b1;
        tick();
        load_valid_l = 1'b0; d_l = 8'hFE;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb sdata[%0d]", k), {31'd0, sdata_l}, {31'd0, k == 0});
            chk($sformatf("lsb sframe[%0d]", k), {31'd0, sframe_l}, 32'd1);
            chk($sformatf("lsb slast[%0d]", k), {31'd0, slast_l}, {31'd0, k == 7});
            tick();
        end
        chk("lsb end sframe", {31'd0, sframe_l}, 32'd0);

        // random traffic against a deserializer model
        sent = 0; rx_words = 0; rx_bits = 0; frame_cycles = 0; rx_word = 8'h00;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (sent == 100 && rx_words == 100) break;
            d = 8'($urandom);
            load_valid = (sent < 100) && ($urandom_range(0, 9) < 6);
            xfer = load_valid && load_ready;
            if (xfer) begin
                q.push_back(d);
                sent++;
            end
            tick();
            if (sframe) begin
                frame_cycles++;
                rx_word = {rx_word[6:0], sdata};
                rx_bits++;
                if (slast) begin
                    chk("rand bits", rx_bits, 32'd8);
                    if (q.size() > 0)
                        chk($sformatf("rand word %0d", rx_words), {24'd0, rx_word},
                            {24'd0, q.pop_front()});
                    else
                        chk("rand unexpected word", 32'd1, 32'd0);
                    rx_words++;
                    rx_bits = 0;
                end
            end
        end
        load_valid = 1'b0;
        tick(); tick();
        chk("rand words", rx_words, 32'd100);
        chk("rand frame cycles", frame_cycles, 32'd800);
        chk("rand queue empty", q.size(), 32'd0);
        chk_idle("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_piso_tx.md
Name: shift_reg_piso_tx

Overview:
- Parallel-in serial-out transmitter: the serialising counterpart of the team's parallel shift registers.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock, with a frame strobe and a last-bit marker.
- A one-word holding buffer allows back-to-back words with no idle cycle between frames.
- Feeds the serial-in deserializer and any downstream bit-serial link.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- d  input  WIDTH  parallel word to transmit.
- load_valid  input  1  d holds a word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- sdata  output  1  serial data bit; registered.
- sframe  output  1  high while sdata carries a valid bit; registered.
- slast  output  1  high during the final bit of each word; registered.

Behaviour:
- Reset: applies on any rising edge with reset=1 and overrides every other event.
  - Reset values: sdata=0, sframe=0, slast=0, load_ready=1.
  - Bit counter = 0, holding buffer empty, state = IDLE.
  - Any word in flight or buffered is discarded.
  - A handshake on the reset edge is ignored.
- Handshake: a word transfers on a rising edge with load_valid=1 and load_ready=1.
  - load_ready = not buffer_full, driven from registers only, with no path from load_valid.
  - d is sampled only on a transfer edge.
- States:
  - IDLE: shifter and buffer are empty; sframe=0, sdata=0.
  - SHIFT: a word is being shifted out.
- IDLE -> SHIFT: on a transfer edge, the word loads directly into the shifter.
  - From that edge: sframe=1 and sdata = first bit (bit WIDTH-1 if MSB_FIRST, else bit 0).
  - Latency is one edge from accept to the first bit on the outputs.
- SHIFT:
  - Each edge advances one bit, so each bit is held for exactly one clock.
  - The bit counter runs 0..WIDTH-1.
  - slast=1 while the counter equals WIDTH-1.
  - A transfer in SHIFT writes the holding buffer, which sets buffer_full and drops load_ready.
- Edge that ends the last bit (counter = WIDTH-1), in priority order:
  - (a) Buffer full: buffer moves into the shifter, buffer empties, load_ready returns to 1 from the next cycle, and the first bit of the new word appears with no gap.
  - (b) Buffer empty and a transfer on this same edge: d bypasses into the shifter, again with no gap.
  - (c) Otherwise: go to IDLE with sframe=0, slast=0, sdata=0.
- Frame timing: sframe stays high continuously across back-to-back words; slast pulses once per word.
- Word boundary: the counter wraps from WIDTH-1 to 0 on each word boundary and never exceeds WIDTH-1.
- Input stability: d may change freely outside transfer edges without affecting the word in flight.

Test Plan:
- Reset check: hold reset=1 for 2 cycles, then release -> load_ready=1, sframe=0, slast=0, sdata=0.
- Single word: WIDTH=8, MSB_FIRST=1, d=8'hA5 pulsed valid for one cycle.
  - sdata = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with sframe=1.
  - slast=1 on the 8th bit only, then sframe=0.
- Back-to-back: 8'hA5 then 8'h3C with load_valid held high.
  - 16 contiguous sframe cycles with two slast pulses.
  - load_ready=0 from the second accept until the first word's last-bit edge.
- Bypass: single 8'hFF, then 8'h00 presented only on the last-bit edge of 8'hFF.
  - sdata = eight 1s immediately followed by eight 0s, with no sframe gap.
- Mid-frame reset: assert reset after 3 bits of 8'hA5 while 8'h3C is buffered.
  - Next cycle: sframe=0, load_ready=1.
  - A following word 8'h81 transmits cleanly; nothing from 8'h3C appears.
- LSB-first: MSB_FIRST=0, d=8'h01 -> sdata = 1,0,0,0,0,0,0,0.
- Random traffic: 100 random words with random load_valid gaps, checked against a bench deserializer model.
  - Expect 100 matches, 0 errors, sframe high for exactly 800 cycles.
